// File: rtl/matmul_pkg.sv
// Shared types for the matrix sequencer: operation codes and FSM states.
package matmul_pkg;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_MUL  = 2'b10,
    OP_RSVD = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/matmul_sequencer_mac_unit.sv
// Single multiplier plus accumulate adder for the MUL dot products.
// MATMUL_SATURATE_EN clamps each accumulate step instead of wrapping.
module mac_unit #(
  parameter int WIDTH = 2
) (
  input  logic                 clock,
  input  logic                 rst,
  input  logic                 first,
  input  logic                 en,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [2*WIDTH-1:0]   acc,
  output logic [2*WIDTH-1:0]   sum_next
);

  localparam int OUT_W = 2 * WIDTH;

  logic [OUT_W-1:0] r_acc;
  logic [OUT_W-1:0] w_prod;
  logic [OUT_W-1:0] w_base;

  assign w_prod = OUT_W'(a) * OUT_W'(b);
  assign w_base = first ? '0 : r_acc;

`ifdef MATMUL_SATURATE_EN
  logic [OUT_W:0] w_wide;
  assign w_wide   = {1'b0, w_base} + {1'b0, w_prod};
  // Operands are unsigned, so a clamped sum can only stay clamped.
  assign sum_next = w_wide[OUT_W] ? '1 : w_wide[OUT_W-1:0];
`else
  assign sum_next = w_base + w_prod;
`endif

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
    end else if (en) begin
      r_acc <= sum_next;
    end
  end

  assign acc = r_acc;

endmodule

// File: rtl/matmul_sequencer.sv
// N x N ADD/SUB/MUL sequencer sharing one MAC and one add/sub unit.
// MATMUL_SATURATE_EN selects saturating MUL accumulation.
module matmul_sequencer
  import matmul_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int N     = 4
) (
  input  logic                       clock,
  input  logic                       rst,
  input  logic                       start,
  input  logic [1:0]                 op,
  input  logic [N*N*WIDTH-1:0]       a_flat,
  input  logic [N*N*WIDTH-1:0]       b_flat,
  output logic [N*N*2*WIDTH-1:0]     c_flat,
  output logic                       busy,
  output logic                       done,
  output logic                       err
);

  localparam int OUT_W = 2 * WIDTH;
  localparam int CW    = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t               r_state;
  op_t                  r_op;
  logic [CW-1:0]        r_i, r_j, r_k;
  logic [N*N*WIDTH-1:0] r_a, r_b;
  logic [OUT_W-1:0]     r_cm [N][N];
  logic                 r_busy, r_done, r_err;

  logic [WIDTH-1:0]     w_am [N][N];
  logic [WIDTH-1:0]     w_bm [N][N];
  logic [WIDTH-1:0]     w_a, w_b;
  logic                 w_mul;
  logic [WIDTH:0]       w_sum;
  logic signed [WIDTH:0] w_dif;
  logic [OUT_W-1:0]     w_as;
  logic [OUT_W-1:0]     w_mac;
  logic [OUT_W-1:0]     w_unused_acc;

  always_comb begin
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        w_am[r][c] = r_a[(r*N+c)*WIDTH +: WIDTH];
        w_bm[r][c] = r_b[(r*N+c)*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    c_flat = '0;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        c_flat[(r*N+c)*OUT_W +: OUT_W] = r_cm[r][c];
      end
    end
  end

  // MUL walks A along row i and B down column j; ADD/SUB use (i,j) for both.
  assign w_mul = (r_op == OP_MUL);
  assign w_a   = w_mul ? w_am[r_i][r_k] : w_am[r_i][r_j];
  assign w_b   = w_mul ? w_bm[r_k][r_j] : w_bm[r_i][r_j];

  assign w_sum = {1'b0, w_a} + {1'b0, w_b};
  assign w_dif = signed'({1'b0, w_a} - {1'b0, w_b});
  assign w_as  = (r_op == OP_SUB) ? OUT_W'(w_dif) : OUT_W'(w_sum);

  mac_unit #(.WIDTH(WIDTH)) u_mac (
    .clock    (clock),
    .rst      (rst),
    .first    (r_k == '0),
    .en       ((r_state == RUN) && w_mul),
    .a        (w_a),
    .b        (w_b),
    .acc      (w_unused_acc),
    .sum_next (w_mac)
  );

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_op    <= OP_ADD;
      r_i     <= '0;
      r_j     <= '0;
      r_k     <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_cm    <= '{default: '0};
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_a    <= a_flat;
            r_b    <= b_flat;
            r_op   <= op_t'(op);
            r_i    <= '0;
            r_j    <= '0;
            r_k    <= '0;
            r_busy <= 1'b1;
            if (op_t'(op) == OP_RSVD) begin
              r_state <= DONE;
              r_done  <= 1'b1;
              r_err   <= 1'b1;
            end else begin
              r_cm    <= '{default: '0};
              r_state <= RUN;
            end
          end
        end
        RUN: begin
          if (w_mul && (r_k != LAST)) begin
            r_k <= r_k + 1'b1;
          end else begin
            r_k <= '0;
            r_cm[r_i][r_j] <= w_mul ? w_mac : w_as;
            if (r_j == LAST) begin
              r_j <= '0;
              if (r_i == LAST) begin
                r_i     <= '0;
                r_state <= DONE;
                r_done  <= 1'b1;
              end else begin
                r_i <= r_i + 1'b1;
              end
            end else begin
              r_j <= r_j + 1'b1;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_err   <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign err  = r_err;

endmodule

// File: tb/tb_matmul_sequencer.sv
// Randomized bench for matmul_sequencer against an arithmetic reference model.
// Honors MATMUL_SATURATE_EN the same way the design build does.
module tb_matmul_sequencer;

  localparam int W    = 2;
  localparam int N    = 4;
  localparam int OW   = 2 * W;
  localparam int AW   = N * N * W;
  localparam int CWID = N * N * OW;
  localparam int MAXV = (1 << OW) - 1;

  logic            clock;
  logic            rst;
  logic            start;
  logic [1:0]      op;
  logic [AW-1:0]   a_flat;
  logic [AW-1:0]   b_flat;
  logic [CWID-1:0] c_flat;
  logic            busy;
  logic            done;
  logic            err;

  int n_chk  = 0;
  int n_pass = 0;
  int expc [N*N];

  matmul_sequencer #(.WIDTH(W), .N(N)) dut (
    .clock  (clock),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a_flat (a_flat),
    .b_flat (b_flat),
    .c_flat (c_flat),
    .busy   (busy),
    .done   (done),
    .err    (err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic int el(input logic [AW-1:0] m, input int r, input int c);
    return int'(m[(r*N+c)*W +: W]);
  endfunction

  function automatic logic [AW-1:0] fill(input int v);
    logic [AW-1:0] m;
    for (int e = 0; e < N*N; e++) m[e*W +: W] = W'(v);
    return m;
  endfunction

  function automatic logic [AW-1:0] ident();
    logic [AW-1:0] m;
    m = '0;
    for (int r = 0; r < N; r++) m[(r*N+r)*W +: W] = W'(1);
    return m;
  endfunction

  // Illegal ops leave the previous expectation untouched.
  task automatic model(input logic [1:0] o, input logic [AW-1:0] a,
                       input logic [AW-1:0] b);
    int s, p;
    if (o == 2'b11) return;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        case (o)
          2'b00: expc[r*N+c] = el(a, r, c) + el(b, r, c);
          2'b01: expc[r*N+c] = (el(a, r, c) - el(b, r, c)) & MAXV;
          default: begin
            s = 0;
            for (int k = 0; k < N; k++) begin
              p = el(a, r, k) * el(b, k, c);
`ifdef MATMUL_SATURATE_EN
              s = (s + p > MAXV) ? MAXV : s + p;
`else
              s = (s + p) % (MAXV + 1);
`endif
            end
            expc[r*N+c] = s;
          end
        endcase
      end
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] o,
                        input logic [AW-1:0] a, input logic [AW-1:0] b,
                        input int chg_cyc, input int pls_cyc);
    int L, dc, nd, bbad;
    logic errd;
    L = (o == 2'b10) ? N*N*N : (o == 2'b11) ? 0 : N*N;
    model(o, a, b);
    @(negedge clock);
    start = 1'b1; op = o; a_flat = a; b_flat = b;
    @(posedge clock); #1;
    start = 1'b0;
    dc = 0; nd = 0; bbad = 0; errd = 1'b0;
    for (int c = 1; c <= L + 3; c++) begin
      if (c == chg_cyc) begin
        a_flat = $urandom;
        b_flat = $urandom;
      end
      start = (c == pls_cyc);
      if (busy !== (c <= L + 1)) bbad++;
      if (done === 1'b1) begin
        nd++;
        if (dc == 0) begin
          dc = c;
          errd = err;
        end
      end
      @(posedge clock); #1;
    end
    start = 1'b0;
    check($sformatf("%s_done_cycle", tag), dc, L + 1);
    check($sformatf("%s_done_count", tag), nd, 1);
    check($sformatf("%s_busy_profile", tag), bbad, 0);
    check($sformatf("%s_err", tag), {31'd0, errd}, {31'd0, o == 2'b11});
    for (int e = 0; e < N*N; e++)
      check($sformatf("%s_c%0d", tag, e), c_flat[e*OW +: OW], expc[e]);
  endtask

  initial begin
    logic [1:0]    ro;
    logic [AW-1:0] ra, rb;
    rst = 1'b1; start = 1'b0; op = 2'b00; a_flat = '0; b_flat = '0;
    foreach (expc[e]) expc[e] = 0;
    #12;
    check("rst_c_flat", {31'd0, |c_flat}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_err", {31'd0, err}, 0);
    @(negedge clock);
    rst = 1'b0;

    run_op("mul_ident", 2'b10, ident(), fill(3), 0, 0);
    run_op("mul_ovf", 2'b10, fill(3), fill(3), 0, 0);
    run_op("sub_neg", 2'b01, fill(0), fill(1), 0, 0);
    run_op("add_max", 2'b00, fill(3), fill(3), 0, 0);
    run_op("mul_ident2", 2'b10, ident(), fill(3), 0, 0);
    run_op("illegal", 2'b11, fill(2), fill(1), 0, 0);
    ra = $urandom; rb = $urandom;
    run_op("mul_ignore", 2'b10, ra, rb, 5, 10);

    // Asynchronous reset part way through a MUL.
    @(negedge clock);
    start = 1'b1; op = 2'b10; a_flat = ident(); b_flat = fill(3);
    @(posedge clock); #1;
    start = 1'b0;
    repeat (19) @(posedge clock);
    #3;
    rst = 1'b1;
    #1;
    check("midrst_c_flat", {31'd0, |c_flat}, 0);
    check("midrst_busy", {31'd0, busy}, 0);
    check("midrst_done", {31'd0, done}, 0);
    check("midrst_err", {31'd0, err}, 0);
    @(negedge clock);
    rst = 1'b0;
    foreach (expc[e]) expc[e] = 0;
    ra = $urandom; rb = $urandom;
    run_op("add_after_rst", 2'b00, ra, rb, 0, 0);

    for (int t = 0; t < 6; t++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom; rb = $urandom;
      run_op($sformatf("rand%0d", t), ro, ra, rb, 0, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
